// File: rtl/rca_pkg.sv
// Shared helpers for the pipelined ripple-carry adder/subtractor.
// Holds the default geometry and the chunk-width calculation.
// The per-stage record is declared in the top module because its width
// follows the WIDTH parameter.
package rca_pkg;

  localparam int RCA_DEF_WIDTH  = 16;
  localparam int RCA_DEF_STAGES = 4;

  // Bits resolved per pipeline stage.
  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/rca_chunk.sv
// Combinational W-bit ripple of full-adder slices.
// One instance of this block resolves one chunk per pipeline stage.
module rca_chunk #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);

  logic [W:0] w_c;

  assign w_c[0] = ci;

  for (genvar gi = 0; gi < W; gi++) begin : g_fa
    assign s[gi]      = a[gi] ^ b[gi] ^ w_c[gi];
    assign w_c[gi+1]  = (a[gi] & b[gi]) | (w_c[gi] & (a[gi] ^ b[gi]));
  end

  assign co = w_c[W];

endmodule

// File: rtl/pipe_rca_addsub.sv
// Pipelined ripple-carry adder/subtractor.
// WIDTH bits are split into STAGES chunks; one chunk resolves per cycle
// with the carry registered between stages. A single global enable
// (downstream free or accepting) advances or freezes the whole pipe.
// Optional feature macro: PIPE_RCA_SAT_EN clamps the sum to the signed
// range on overflow; without it the sum is the raw modular result.
module pipe_rca_addsub
  import rca_pkg::*;
#(
  parameter int WIDTH  = RCA_DEF_WIDTH,
  parameter int STAGES = RCA_DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CHUNK = chunk_width(WIDTH, STAGES);

  // Beat as it travels: operands ride along so later stages can finish
  // their chunks, and sum_lo accumulates the chunks already resolved.
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] a_hi;
    logic [WIDTH-1:0] b_hi;
    logic [WIDTH-1:0] sum_lo;
    logic             carry;
  } stage_t;

  stage_t           r_stage [STAGES];
  stage_t           w_src   [STAGES];
  stage_t           w_nxt   [STAGES];
  logic [CHUNK-1:0] w_s     [STAGES];
  logic             w_co    [STAGES];
  logic             w_en;
  stage_t           w_last;
  logic             w_ovf;

  assign w_last    = r_stage[STAGES-1];
  assign w_en      = !w_last.valid | out_ready;
  assign in_ready  = w_en;
  assign out_valid = w_last.valid;

  // Stage inputs: stage 0 takes the prepared operands (zeroed for bubbles
  // so idle outputs read as zero), later stages take the previous register.
  always_comb begin
    w_src[0] = '0;
    if (in_valid) begin
      w_src[0].valid = 1'b1;
      w_src[0].a_hi  = a;
      w_src[0].b_hi  = sub ? ~b : b;
      w_src[0].carry = sub ? ~cin : cin;
    end
    for (int k = 1; k < STAGES; k++) begin
      w_src[k] = r_stage[k-1];
    end
  end

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    rca_chunk #(
      .W (CHUNK)
    ) u_chunk (
      .a  (w_src[gi].a_hi[gi*CHUNK +: CHUNK]),
      .b  (w_src[gi].b_hi[gi*CHUNK +: CHUNK]),
      .ci (w_src[gi].carry),
      .s  (w_s[gi]),
      .co (w_co[gi])
    );
  end

  // Merge each stage's resolved chunk and its carry into the travelling record.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      w_nxt[k]                          = w_src[k];
      w_nxt[k].sum_lo[k*CHUNK +: CHUNK] = w_s[k];
      w_nxt[k].carry                    = w_co[k];
    end
  end

  // Pipe registers: cleared on reset, frozen together when the output stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        r_stage[k] <= '0;
      end
    end else if (w_en) begin
      for (int k = 0; k < STAGES; k++) begin
        r_stage[k] <= w_nxt[k];
      end
    end
  end

  // Signed overflow: operands agree in sign but the result does not.
  assign w_ovf = (w_last.a_hi[WIDTH-1] == w_last.b_hi[WIDTH-1]) &
                 (w_last.sum_lo[WIDTH-1] != w_last.a_hi[WIDTH-1]);

  assign cout = w_last.carry;
  assign ovf  = w_ovf;

`ifdef PIPE_RCA_SAT_EN
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  // Clamp toward the sign of the operands: positive operands overflow high.
  always_comb begin
    sum = w_last.sum_lo;
    if (w_ovf) begin
      sum = w_last.a_hi[WIDTH-1] ? SAT_MIN : SAT_MAX;
    end
  end
`else
  assign sum = w_last.sum_lo;
`endif

endmodule

// File: tb/tb_pipe_rca_addsub.sv
// Self-checking bench for pipe_rca_addsub (16-bit, 4 stages).
// An arithmetic model predicts every retired beat; directed tests pin
// latency and hand-computed values.
module tb_pipe_rca_addsub;

  localparam int W = 16;
  localparam int S = 4;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int errors = 0;
  int checks = 0;
  int retired = 0;
  exp_t exp_q[$];

  logic         hold_valid = 1'b0;
  logic [W-1:0] h_sum;
  logic         h_cout;
  logic         h_ovf;

  pipe_rca_addsub #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Plain integer arithmetic: unsigned for result/carry, signed for overflow.
  function automatic exp_t model(input logic [W-1:0] fa, input logic [W-1:0] fb,
                                 input logic fcin, input logic fsub);
    exp_t e;
    int ua, ub, sa, sb, c, ur, sr;
    ua = int'(fa);
    ub = int'(fb);
    sa = int'($signed(fa));
    sb = int'($signed(fb));
    c  = fcin ? 1 : 0;
    if (!fsub) begin
      ur = ua + ub + c;
      sr = sa + sb + c;
      e.cout = (ur > 65535);
    end else begin
      ur = ua - ub - c;
      sr = sa - sb - c;
      e.cout = (ur >= 0);
    end
    e.ovf = (sr > 32767) || (sr < -32768);
    e.sum = ur[W-1:0];
`ifdef PIPE_RCA_SAT_EN
    if (e.ovf) e.sum = (sr > 0) ? 16'h7FFF : 16'h8000;
`endif
    return e;
  endfunction

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endfunction

  // Compare process: sees the handshake state that the next rising edge acts on.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      hold_valid = 1'b0;
    end else begin
      if (hold_valid) begin
        check("stall_hold_valid", {31'd0, out_valid}, 32'd1);
        check("stall_hold_data", {15'd0, sum, cout, ovf}, {15'd0, h_sum, h_cout, h_ovf});
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got sum=%h with no beat outstanding", sum);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("model_result", {15'd0, sum, cout, ovf}, {15'd0, e.sum, e.cout, e.ovf});
          retired++;
        end
      end
      hold_valid = out_valid && !out_ready;
      h_sum  = sum;
      h_cout = cout;
      h_ovf  = ovf;
    end
  end

  // Present one beat (call just after a rising edge); returns after acceptance.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                      input logic tcin, input logic tsub);
    int n;
    n = 0;
    in_valid = 1'b1;
    a = ta;
    b = tb_;
    cin = tcin;
    sub = tsub;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stuck 0 for %0d cycles, required 1", n);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Send one beat with out_ready=1, measure latency and compare with literals.
  task automatic directed(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic tcin, input logic tsub,
                          input logic [W-1:0] xsum, input logic xcout, input logic xovf);
    int cyc;
    send(ta, tb_, tcin, tsub);
    cyc = 1;
    while (!out_valid && cyc < 50) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    $display("beat %s: a=%h b=%h cin=%0d sub=%0d -> sum=%h cout=%0d ovf=%0d after %0d cycles",
             name, ta, tb_, tcin, tsub, sum, cout, ovf, cyc);
    check({name, "_latency"}, cyc, S);
    check({name, "_sum"}, {16'd0, sum}, {16'd0, xsum});
    check({name, "_cout"}, {31'd0, cout}, {31'd0, xcout});
    check({name, "_ovf"}, {31'd0, ovf}, {31'd0, xovf});
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] bp_a   [8] = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'h0001, 16'h1234, 16'hAAAA, 16'h8000, 16'h00FF};
  logic [W-1:0] bp_b   [8] = '{16'h0001, 16'h0001, 16'h0001, 16'h0002, 16'h1234, 16'h5555, 16'h8000, 16'h0F01};
  logic         bp_cin [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  logic         bp_sub [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    logic [3:0] pat;
    int target;
    int n;
    pat = 4'b1001;

    // Reset held 3 cycles with in_valid asserted.
    rst_n = 1'b0;
    in_valid = 1'b1;
    a = 16'h1111;
    b = 16'h2222;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset_out_valid", {31'd0, out_valid}, 32'd0);
      check("reset_sum", {16'd0, sum}, 32'd0);
    end
    rst_n = 1'b1;
    in_valid = 1'b0;
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      check("post_reset_idle", {31'd0, out_valid}, 32'd0);
    end

    // Model pins: hand-computed values for each operation class.
    directed("add",  16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    directed("sub",  16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
`ifdef PIPE_RCA_SAT_EN
    directed("ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1);
`else
    directed("ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
`endif
    directed("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    directed("subc", 16'h1000, 16'h0001, 1'b1, 1'b1, 16'h0FFE, 1'b1, 1'b0);

    // Backpressure: 8 beats while out_ready cycles 1,0,0,1.
    target = retired + 8;
    fork
      begin
        for (int i = 0; i < 8; i++) send(bp_a[i], bp_b[i], bp_cin[i], bp_sub[i]);
      end
      begin
        n = 0;
        while (retired < target && n < 400) begin
          out_ready = pat[n % 4];
          @(posedge clk);
          #1;
          n++;
        end
        out_ready = 1'b1;
      end
    join
    $display("backpressure: retired %0d of 8 beats", retired - (target - 8));
    check("bp_all_retired", retired, target);

    // Mid-stream reset: 3 beats in flight are discarded.
    send(16'h0101, 16'h0202, 1'b0, 1'b0);
    send(16'h0303, 16'h0404, 1'b0, 1'b0);
    send(16'h0505, 16'h0606, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    directed("after_rst", 16'h00F0, 16'h000F, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
    end
    check("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
